mult_rr_arbiter: RTL and testbench
==================================

# mult_rr_arbiter

Round-robin arbiter and sequencer that shares one registered 4x4 unsigned multiplier among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the chosen operands into the shared multiplier. It captures the registered product and returns it on a single response channel, tagged with the requester index. It sits between the requester ports and the multiplier instance; both run on the same clock and reset.

## Interface

**Parameters**
- BITS, default 4: operand width; the product is 2*BITS.
- NREQ, default 4: number of requesters; legal range 2..8.
- ID_W, default 2: requester-index width; must equal $clog2(NREQ).

**Ports** (one clock; reset is asynchronous and active-high)
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- req_valid, in, NREQ: bit i is high when requester i has an operand pair.
- req_ready, out, NREQ: bit i is the one-hot grant to requester i.
- req_a, in, NREQ*BITS: operand A; requester i uses bits [i*BITS +: BITS].
- req_b, in, NREQ*BITS: operand B, same packing as req_a.
- mul_a, out, BITS: A operand to the multiplier.
- mul_b, out, BITS: B operand to the multiplier.
- mul_p, in, 2*BITS: registered product from the multiplier.
- rsp_valid, out, 1: a response is available.
- rsp_ready, in, 1: the consumer accepts the response.
- rsp_id, out, ID_W: index of the requester that owns rsp_product.
- rsp_product, out, 2*BITS: A*B, unsigned.
- done_cnt, out, 8: count of completed responses; wraps 255 -> 0.

## Operation

The FSM has four states: IDLE, ISSUE, CAPT, RESP.

**IDLE**
- Search req_valid for the first set bit, starting at pointer ptr and scanning upward with wrap.
- Drive req_ready[g] high combinationally for the winner g. All other req_ready bits are 0.
- If no req_valid bit is set, stay in IDLE with req_ready = 0.
- On the edge where a grant is given:
  - op_a <= req_a[g] and op_b <= req_b[g];
  - op_id <= g;
  - ptr <= (g+1) mod NREQ;
  - go to ISSUE.

**Outside IDLE**
- req_ready = 0 in ISSUE, CAPT and RESP. No request is accepted in those states.

**Operand drive**
- mul_a = op_a and mul_b = op_b at all times, driven from registers.

**ISSUE**
- Operands are stable at the multiplier. The multiplier registers the product on the next edge.
- Next state: CAPT, unconditionally.

**CAPT**
- On the edge:
  - rsp_product <= mul_p;
  - rsp_id <= op_id;
  - rsp_valid <= 1;
  - done_cnt <= done_cnt + 1;
  - go to RESP.

**RESP**
- Hold rsp_valid, rsp_id and rsp_product stable until rsp_ready is high at an edge.
- On that edge, rsp_valid <= 0 and the FSM returns to IDLE.
- rsp_product and rsp_id keep their last values after rsp_valid drops.

**Requester and arithmetic rules**
- A requester holds req_valid, req_a and req_b stable until it sees req_ready. Deasserting req_valid before the grant is allowed; that requester simply loses eligibility.
- The product is unsigned and full width, with no truncation. The maximum is (2^BITS-1)^2 = 225 for BITS=4.

**Reset** (asynchronous, effective immediately, including mid-transaction)
- state = IDLE, ptr = 0.
- op_a, op_b and op_id = 0, so mul_a = mul_b = 0.
- rsp_valid = 0, rsp_id = 0, rsp_product = 0, done_cnt = 0.
- req_ready = 0 while rst is high.
- Any in-flight operation is dropped with no response.

## Timing

- Grant: combinational in IDLE, in the same cycle req_valid is seen. The accept edge E0 is the edge where req_valid[g] & req_ready[g] is high.
- Latency: rsp_valid is high after edge E0+2, i.e. ISSUE during E0..E1 and CAPT during E1..E2.
- Throughput: with rsp_ready held high, one transaction per 4 cycles: IDLE, ISSUE, CAPT, RESP.
- rsp_valid never drops without rsp_ready. Response fields never change while rsp_valid=1.
- Multiplier contract: mul_p at edge E2 reflects mul_a/mul_b sampled at edge E1.

## Test plan

- **Reset values:** assert rst mid-cycle -> all outputs read 0 immediately, with no clock needed.
- **Single request:** requester 2 sends A=7, B=9 -> req_ready[2] is high in the same cycle; rsp_valid is high after E0+2 with rsp_id=2, rsp_product=63, done_cnt=1.
- **All four requesting:** all requesters valid at once, rsp_ready=1, after reset -> grant order 0,1,2,3, then 0 again. Each response carries its own id and product. Accepts are 4 cycles apart.
- **Fairness and extremes:** after serving requester 1, only requesters 0 and 3 are valid -> 3 is granted before 0. A=15, B=15 -> rsp_product=225. A=0, B=13 -> rsp_product=0.
- **Backpressure:** hold rsp_ready=0 for 5 cycles while in RESP -> rsp_valid, rsp_id and rsp_product stay stable; req_ready stays 0 despite pending req_valid. Raise rsp_ready -> IDLE on the next edge, and the next grant follows.
- **Reset mid-operation and counter wrap:** pulse rst during CAPT -> no response, done_cnt=0, and the next grant starts at requester 0. Complete 256 transactions -> done_cnt wraps to 0.

Source files
------------

// File: rtl/mult_rr_arbiter_if.sv
// Requester, multiplier and response signals for mult_rr_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mult_rr_arbiter_if #(
  parameter int unsigned BITS = 4,
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BITS-1:0] req_a;
  logic [NREQ*BITS-1:0] req_b;
  logic [BITS-1:0]      mul_a;
  logic [BITS-1:0]      mul_b;
  logic [2*BITS-1:0]    mul_p;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [2*BITS-1:0]    rsp_product;
  logic [7:0]           done_cnt;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, done_cnt
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, done_cnt
  );
endinterface

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter that time-shares one registered multiplier among NREQ
// requesters and returns each product on a single tagged response channel.
module mult_rr_arbiter #(
  parameter int unsigned BITS = 4,
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  mult_rr_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [BITS-1:0]   op_a_q, op_a_d;
  logic [BITS-1:0]   op_b_q, op_b_d;
  logic [ID_W-1:0]   op_id_q, op_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [2*BITS-1:0] rsp_product_q, rsp_product_d;
  logic [7:0]        done_cnt_q, done_cnt_d;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   cand;
  logic [NREQ-1:0]   gnt_onehot;
  logic [BITS-1:0]   gnt_a;
  logic [BITS-1:0]   gnt_b;

  // Scan req_valid upward from ptr_q with wrap; the first set bit wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found && bus_io.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Select the winner's operands and form the one-hot grant vector.
  always_comb begin
    gnt_a      = '0;
    gnt_b      = '0;
    gnt_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        gnt_a         = bus_io.req_a[i*BITS +: BITS];
        gnt_b         = bus_io.req_b[i*BITS +: BITS];
        gnt_onehot[i] = gnt_found;
      end
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> CAPT -> RESP sequence.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_id_d       = op_id_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    done_cnt_d    = done_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          op_a_d  = gnt_a;
          op_b_d  = gnt_b;
          op_id_d = gnt_id;
          ptr_d   = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
          state_d = StIssue;
        end
      end
      // Operands sit at the multiplier; it registers the product this edge.
      StIssue: state_d = StCapt;
      StCapt: begin
        rsp_product_d = bus_io.mul_p;
        rsp_id_d      = op_id_q;
        rsp_valid_d   = 1'b1;
        done_cnt_d    = done_cnt_q + 8'd1;
        state_d       = StResp;
      end
      StResp: begin
        if (bus_io.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any in-flight operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_id_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      done_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_id_q       <= op_id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      done_cnt_q    <= done_cnt_d;
    end
  end

  // Grant is combinational in IDLE only, and forced low while reset is held.
  assign bus_io.req_ready   = (state_q == StIdle && !rst_i) ? gnt_onehot : '0;
  assign bus_io.mul_a       = op_a_q;
  assign bus_io.mul_b       = op_b_q;
  assign bus_io.rsp_valid   = rsp_valid_q;
  assign bus_io.rsp_id      = rsp_id_q;
  assign bus_io.rsp_product = rsp_product_q;
  assign bus_io.done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Self-checking bench for mult_rr_arbiter: directed vector table, corner
// sequences and a randomized run against a behavioural arbitration model.
module tb_mult_rr_arbiter;
  localparam int BITS = 4;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_rr_arbiter_if #(.BITS(BITS), .NREQ(NREQ), .ID_W(ID_W)) bus ();

  mult_rr_arbiter #(.BITS(BITS), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  // Registered multiplier in the environment.
  always @(posedge clk) bus.mul_p <= 8'(bus.mul_a) * 8'(bus.mul_b);

  int n_chk = 0;
  int n_err = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] av;
    logic [15:0] bv;
    int          exp_id;
    int          exp_prod;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int winner(input logic [3:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_ptr + k) % NREQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int lane(input logic [15:0] v, input int i);
    logic [15:0] t;
    t = v >> (i * 4);
    return int'(t[3:0]);
  endfunction

  // Starts in IDLE a little after an edge; returns in IDLE a little after an edge.
  task automatic run_txn(input string tag, input logic [3:0] mask, input logic [15:0] av,
                         input logic [15:0] bv, input int exp_g, input int exp_p,
                         input int stall);
    bus.req_valid = mask;
    bus.req_a     = av;
    bus.req_b     = bv;
    bus.rsp_ready = (stall == 0);
    #1;
    chk({tag, "/ready"}, 32'(bus.req_ready), 32'(1 << exp_g));
    @(posedge clk); #1;
    bus.req_valid = '0;
    m_ptr = (exp_g + 1) % NREQ;
    chk({tag, "/mul_a"}, 32'(bus.mul_a), 32'(lane(av, exp_g)));
    chk({tag, "/mul_b"}, 32'(bus.mul_b), 32'(lane(bv, exp_g)));
    chk({tag, "/valid_issue"}, 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "/valid_capt"}, 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    m_cnt = (m_cnt + 1) % 256;
    chk({tag, "/valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "/id"}, 32'(bus.rsp_id), 32'(exp_g));
    chk({tag, "/product"}, 32'(bus.rsp_product), 32'(exp_p));
    chk({tag, "/done_cnt"}, 32'(bus.done_cnt), 32'(m_cnt));
    if (stall > 0) bus.req_valid = 4'hF;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, "/hold_id"}, 32'(bus.rsp_id), 32'(exp_g));
      chk({tag, "/hold_product"}, 32'(bus.rsp_product), 32'(exp_p));
      chk({tag, "/hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    if (stall > 0) begin
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "/valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "/id_kept"}, 32'(bus.rsp_id), 32'(exp_g));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  mask;
    logic [15:0] av;
    logic [15:0] bv;
    int          g;
    int          p;
    int          last;

    vecs[0] = '{4'b0010, 16'h4352, 16'h7634, 1, 15};
    vecs[1] = '{4'b1001, 16'hF00E, 16'hF00E, 3, 225};
    vecs[2] = '{4'b1001, 16'h8000, 16'h500D, 0, 0};
    vecs[3] = '{4'b1111, 16'h12C3, 16'h45B6, 1, 132};
    vecs[4] = '{4'b0001, 16'h0001, 16'h000F, 0, 15};
    vecs[5] = '{4'b0100, 16'h0F00, 16'h0100, 2, 15};
    vecs[6] = '{4'b0110, 16'h0790, 16'h0860, 1, 54};
    vecs[7] = '{4'b1000, 16'hA000, 16'hA000, 3, 100};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("init/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("init/rsp_product", 32'(bus.rsp_product), 32'd0);
    chk("init/done_cnt", 32'(bus.done_cnt), 32'd0);

    // Single request from requester 2.
    run_txn("single", 4'b0100, 16'h0700, 16'h0900, 2, 63, 0);

    // Asynchronous reset mid-cycle clears everything without an edge.
    bus.req_valid = 4'hF;
    rst = 1'b1;
    #1;
    chk("rst/req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst/mul_a", 32'(bus.mul_a), 32'd0);
    chk("rst/mul_b", 32'(bus.mul_b), 32'd0);
    chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst/rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst/rsp_product", 32'(bus.rsp_product), 32'd0);
    chk("rst/done_cnt", 32'(bus.done_cnt), 32'd0);
    bus.req_valid = '0;
    #1 rst = 1'b0;
    m_ptr = 0;
    m_cnt = 0;

    // Directed vectors: fairness, extremes, pointer wrap.
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].mask, vecs[i].av, vecs[i].bv,
              vecs[i].exp_id, vecs[i].exp_prod, 0);
    end

    // Backpressure for 5 cycles, then the next grant follows directly.
    run_txn("bp", 4'b0101, 16'h0306, 16'h0504, 0, 24, 5);
    run_txn("after_bp", 4'b0101, 16'h0306, 16'h0504, 2, 15, 0);

    // All four requesting continuously after reset.
    rst = 1'b1;
    #1 rst = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    @(posedge clk); #1;
    bus.req_valid = 4'hF;
    bus.req_a     = 16'h4321;
    bus.req_b     = 16'h8765;
    bus.rsp_ready = 1'b1;
    #1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      chk($sformatf("all/grant%0d", k), 32'(bus.req_ready), 32'(1 << g));
      if (k > 0) chk($sformatf("all/spacing%0d", k), 32'(cyc - last), 32'd4);
      last = cyc;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      m_cnt++;
      chk($sformatf("all/id%0d", k), 32'(bus.rsp_id), 32'(g));
      chk($sformatf("all/product%0d", k), 32'(bus.rsp_product), 32'((g + 1) * (g + 5)));
      chk($sformatf("all/done%0d", k), 32'(bus.done_cnt), 32'(m_cnt));
      @(posedge clk); #1;
    end
    m_ptr = 1;
    bus.req_valid = '0;

    // Reset pulse while in CAPT drops the operation.
    bus.req_valid = 4'b0100;
    bus.req_a     = 16'h0D00;
    bus.req_b     = 16'h0B00;
    #1;
    chk("midrst/grant", 32'(bus.req_ready), 32'b0100);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst/done_cnt", 32'(bus.done_cnt), 32'd0);
    chk("midrst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst/mul_a", 32'(bus.mul_a), 32'd0);
    #1 rst = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      chk("midrst/no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 4'hF;
    #1;
    chk("midrst/first_grant", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    @(posedge clk); #1;

    // Randomized run of 256 transactions; done_cnt must wrap to 0.
    rst = 1'b1;
    #1 rst = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    @(posedge clk); #1;
    for (int t = 0; t < 256; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.req_valid = '0;
        #1;
        chk("rand/idle_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
      end
      mask = 4'($urandom_range(1, 15));
      av   = 16'($urandom);
      bv   = 16'($urandom);
      if (t % 16 == 0) begin
        av = 16'hFFFF;
        bv = 16'hFFFF;
      end
      g = winner(mask);
      p = lane(av, g) * lane(bv, g);
      run_txn($sformatf("rand%0d", t), mask, av, bv, g, p,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    chk("wrap/done_cnt", 32'(bus.done_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
